// File: rtl/display_sequencer.sv
// Picks the picture source for the 16x16 red/green LED matrix and runs the
// end-of-game freeze / blink / row-wipe animation; also gates the game core.
module display_sequencer #(
    parameter int BLINK_TICKS   = 4,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              start,
    input  logic              game_over,
    input  logic [15:0][15:0] play_red,
    input  logic [15:0][15:0] play_grn,
    input  logic [15:0][15:0] title_red,
    input  logic [15:0][15:0] title_grn,
    input  logic [15:0][15:0] over_red,
    input  logic [15:0][15:0] over_grn,
    output logic [15:0][15:0] RedPixels,
    output logic [15:0][15:0] GrnPixels,
    output logic              play_en,
    output logic [2:0]        mode
);

    localparam int TW  = $clog2(BLINK_TICKS + 1);
    localparam int TGW = $clog2(FLASH_TOGGLES + 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(BLINK_TICKS - 1);
    localparam logic [TGW-1:0] TOG_LAST  = TGW'(FLASH_TOGGLES - 1);

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_PLAY  = 3'd1,
        S_FLASH = 3'd2,
        S_WIPE  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t            state_q;
    logic [TW-1:0]     tick_cnt_q;
    logic [TGW-1:0]    tog_cnt_q;
    logic              phase_q;
    logic [4:0]        row_cnt_q;
    logic              play_en_q;
    logic [15:0][15:0] snap_red_q;
    logic [15:0][15:0] snap_grn_q;
    logic [15:0][15:0] red_q;
    logic [15:0][15:0] grn_q;
    logic [15:0][15:0] red_d;
    logic [15:0][15:0] grn_d;

    // Source selection follows the current state; the register adds one cycle.
    always_comb begin
        red_d = '0;
        grn_d = '0;
        case (state_q)
            S_TITLE: begin
                red_d = title_red;
                grn_d = title_grn;
            end
            S_PLAY: begin
                red_d = play_red;
                grn_d = play_grn;
            end
            S_FLASH: begin
                if (!phase_q) begin
                    red_d = snap_red_q;
                    grn_d = snap_grn_q;
                end
            end
            S_WIPE: begin
                for (int r = 0; r < 16; r++) begin
                    if (5'(r) < row_cnt_q) begin
                        red_d[r] = over_red[r];
                        grn_d[r] = over_grn[r];
                    end else begin
                        red_d[r] = snap_red_q[r];
                        grn_d[r] = snap_grn_q[r];
                    end
                end
            end
            S_OVER: begin
                red_d = over_red;
                grn_d = over_grn;
            end
            default: begin
                red_d = '0;
                grn_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_TITLE;
            tick_cnt_q <= '0;
            tog_cnt_q  <= '0;
            phase_q    <= 1'b0;
            row_cnt_q  <= '0;
            play_en_q  <= 1'b0;
            snap_red_q <= '0;
            snap_grn_q <= '0;
            red_q      <= '0;
            grn_q      <= '0;
        end else begin
            red_q <= red_d;
            grn_q <= grn_d;
            case (state_q)
                S_TITLE: begin
                    if (start) begin
                        state_q   <= S_PLAY;
                        play_en_q <= 1'b1;
                    end
                end
                S_PLAY: begin
                    // game_over has priority over a simultaneous start
                    if (game_over) begin
                        state_q    <= S_FLASH;
                        play_en_q  <= 1'b0;
                        snap_red_q <= play_red;
                        snap_grn_q <= play_grn;
                        tick_cnt_q <= '0;
                        tog_cnt_q  <= '0;
                        phase_q    <= 1'b0;
                    end
                end
                S_FLASH: begin
                    if (tick) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
                            tog_cnt_q  <= tog_cnt_q + TGW'(1);
                            if (tog_cnt_q == TOG_LAST) begin
                                state_q   <= S_WIPE;
                                row_cnt_q <= '0;
                                phase_q   <= 1'b0;
                            end else begin
                                phase_q <= ~phase_q;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                S_WIPE: begin
                    if (tick) begin
                        row_cnt_q <= row_cnt_q + 5'd1;
                        if (row_cnt_q == 5'd15) begin
                            state_q <= S_OVER;
                        end
                    end
                end
                S_OVER: begin
                    if (start) begin
                        state_q <= S_TITLE;
                    end
                end
                default: begin
                    state_q   <= S_TITLE;
                    play_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign RedPixels = red_q;
    assign GrnPixels = grn_q;
    assign play_en   = play_en_q;
    assign mode      = state_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized bench for display_sequencer against a tick-counting behavioural
// model of the title/play/flash/wipe/over screen sequence.
module tb_display_sequencer;

    localparam int BT = 2;
    localparam int FT = 4;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              tick      = 1'b0;
    logic              start     = 1'b0;
    logic              game_over = 1'b0;
    logic [15:0][15:0] play_red  = '0;
    logic [15:0][15:0] play_grn  = '0;
    logic [15:0][15:0] title_red = '0;
    logic [15:0][15:0] title_grn = '0;
    logic [15:0][15:0] over_red  = '0;
    logic [15:0][15:0] over_grn  = '0;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;
    logic              play_en;
    logic [2:0]        mode;

    display_sequencer #(.BLINK_TICKS(BT), .FLASH_TOGGLES(FT)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .game_over(game_over),
        .play_red(play_red), .play_grn(play_grn), .title_red(title_red), .title_grn(title_grn),
        .over_red(over_red), .over_grn(over_grn), .RedPixels(RedPixels), .GrnPixels(GrnPixels),
        .play_en(play_en), .mode(mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: screen index plus total ticks seen in the blink and rows revealed.
    int                m_state = 0;
    int                m_fticks = 0;
    int                m_rows = 0;
    logic [15:0][15:0] m_snap_r = '0;
    logic [15:0][15:0] m_snap_g = '0;
    logic [15:0][15:0] e_red = '0;
    logic [15:0][15:0] e_grn = '0;
    int                e_mode = 0;
    logic              e_en = 1'b0;

    task automatic model_reset();
        m_state = 0; m_fticks = 0; m_rows = 0;
        m_snap_r = '0; m_snap_g = '0;
        e_red = '0; e_grn = '0; e_mode = 0; e_en = 1'b0;
    endtask

    task automatic model_clock();
        case (m_state)
            0: begin e_red = title_red; e_grn = title_grn; end
            1: begin e_red = play_red; e_grn = play_grn; end
            2: begin
                if (((m_fticks / BT) % 2) == 1) begin e_red = '0; e_grn = '0; end
                else begin e_red = m_snap_r; e_grn = m_snap_g; end
            end
            3: begin
                for (int r = 0; r < 16; r++) begin
                    e_red[r] = (r < m_rows) ? over_red[r] : m_snap_r[r];
                    e_grn[r] = (r < m_rows) ? over_grn[r] : m_snap_g[r];
                end
            end
            default: begin e_red = over_red; e_grn = over_grn; end
        endcase
        case (m_state)
            0: if (start) m_state = 1;
            1: if (game_over) begin
                m_state = 2; m_snap_r = play_red; m_snap_g = play_grn; m_fticks = 0;
            end
            2: if (tick) begin
                m_fticks++;
                if (m_fticks == BT * FT) begin m_state = 3; m_rows = 0; end
            end
            3: if (tick) begin
                m_rows++;
                if (m_rows == 16) m_state = 4;
            end
            default: if (start) m_state = 0;
        endcase
        e_mode = m_state;
        e_en   = (m_state == 1);
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        @(negedge clk);
        check("mode", 256'(mode), 256'(e_mode));
        check("play_en", 256'(play_en), 256'(e_en));
        check("red", RedPixels, e_red);
        check("grn", GrnPixels, e_grn);
        tick = 1'b0; start = 1'b0; game_over = 1'b0;
    endtask

    task automatic rand_play();
        for (int r = 0; r < 16; r++) begin
            play_red[r] = 16'($urandom);
            play_grn[r] = 16'($urandom);
        end
    endtask

    task automatic rand_static();
        for (int r = 0; r < 16; r++) begin
            title_red[r] = 16'($urandom); title_grn[r] = 16'($urandom);
            over_red[r]  = 16'($urandom); over_grn[r]  = 16'($urandom);
        end
    endtask

    task automatic run_until(input int target, input int budget);
        for (int i = 0; i < budget && m_state != target; i++) begin
            rand_play();
            tick = 1'($urandom_range(0, 1));
            start = (m_state == 0 || m_state == 4);
            game_over = (m_state == 1);
            step();
        end
        check("reach_mode", 256'(mode), 256'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 16; r++) title_red[r] = 16'hFFFF;
        repeat (2) @(negedge clk);
        check("rst_mode", 256'(mode), 256'(0));
        check("rst_en", 256'(play_en), 256'(0));
        check("rst_red", RedPixels, 256'(0));
        check("rst_grn", GrnPixels, 256'(0));
        reset_n = 1'b1;
        step();
        game_over = 1'b1; step();
        start = 1'b1; step();
        play_grn[3] = 16'h00F0; step(); step();

        // First game-over: blink with changing play inputs, then wipe.
        play_red[0] = 16'h8001; game_over = 1'b1; step();
        for (int r = 0; r < 16; r++) over_red[r] = 16'($urandom);
        run_until(3, 200);
        run_until(4, 200);
        start = 1'b1; step();
        start = 1'b1; step();

        // Simultaneous start/game_over, then a long tick-free hold in FLASH.
        for (int r = 0; r < 16; r++) begin
            play_red[r] = 16'h5555; over_red[r] = 16'hAAAA;
        end
        game_over = 1'b1; start = 1'b1; step();
        for (int i = 0; i < 100; i++) begin rand_play(); step(); end
        run_until(3, 200);
        for (int k = 0; k < 16; k++) begin tick = 1'b1; step(); step(); end
        check("wipe_done", 256'(mode), 256'(4));

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) rand_static();
            if ($urandom_range(0, 3) == 0) rand_play();
            tick = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 9) == 0);
            game_over = ($urandom_range(0, 9) == 0);
            step();
        end

        // Asynchronous reset in the middle of a wipe.
        run_until(3, 400);
        for (int k = 0; k < 5; k++) begin tick = 1'b1; step(); end
        for (int r = 0; r < 16; r++) title_red[r] = 16'hFFFF;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_mode", 256'(mode), 256'(0));
        check("arst_en", 256'(play_en), 256'(0));
        check("arst_red", RedPixels, 256'(0));
        check("arst_grn", GrnPixels, 256'(0));
        @(negedge clk);
        check("arst_hold_red", RedPixels, 256'(0));
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            tick = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 3) == 0);
            game_over = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Owns the 16x16 red/green LED matrix and decides which picture source drives it on every cycle: title screen, live playfield, or game-over screen.
- Sequences the end-of-game transition:
  - freezes the final playfield;
  - blinks it;
  - wipes the over screen in row by row.
- Sits between the game core, the static screen generators and the LED driver.
- Also gates the game core through play_en.

Parameters:
BLINK_TICKS, 4, ticks per blink half-period in FLASH (>=1)
FLASH_TOGGLES, 6, number of blank/show toggles before the wipe starts (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle animation strobe from the clock divider
start  input  1  one-cycle start/restart pulse (already debounced)
game_over  input  1  one-cycle pulse from game core, topped out
play_red  input  [15:0][15:0]  live playfield red plane
play_grn  input  [15:0][15:0]  live playfield green plane
title_red  input  [15:0][15:0]  title screen red plane
title_grn  input  [15:0][15:0]  title screen green plane
over_red  input  [15:0][15:0]  game-over screen red plane
over_grn  input  [15:0][15:0]  game-over screen green plane
RedPixels  output  [15:0][15:0]  registered red plane to LED driver
GrnPixels  output  [15:0][15:0]  registered green plane to LED driver
play_en  output  1  game core may advance (high only in PLAY)
mode  output  [2:0]  current state encoding, for debug and LED status

Behaviour:
- Reset (async, reset_n low):
  - state=TITLE (mode=0);
  - RedPixels=GrnPixels=0, play_en=0;
  - snapshot, tick_cnt, tog_cnt, phase and row_cnt all cleared.
  - Reset mid-animation aborts immediately to these values.
- All outputs are registered. Pixel outputs reflect the selected source one cycle after the source value, i.e. one cycle of latency.
- State encodings: TITLE=0, PLAY=1, FLASH=2, WIPE=3, OVER=4.
- TITLE:
  - Output title planes.
  - start -> PLAY.
  - game_over is ignored.
- PLAY:
  - Output play planes as a pass-through.
  - play_en=1 on the cycle after entry (registered).
  - game_over -> FLASH. The same edge captures play_red/play_grn into the snapshot, play_en drops on the next cycle, and tick_cnt, tog_cnt and phase are cleared.
  - start is ignored. If start and game_over arrive in the same cycle, game_over wins.
- FLASH:
  - Output snapshot when phase=0; output all-zero when phase=1.
  - On each tick, tick_cnt increments. When tick_cnt reaches BLINK_TICKS-1, tick_cnt goes to 0, phase toggles and tog_cnt increments.
  - When the toggle that makes tog_cnt==FLASH_TOGGLES occurs -> WIPE, with row_cnt=0 and phase=0.
  - tick absent means nothing advances.
- WIPE:
  - For each row r: output over row r if r < row_cnt, else snapshot row r.
  - On each tick, row_cnt increments (5-bit, 0..16).
  - On the tick that makes row_cnt=16 -> OVER. Row 15 first shows the over screen on the OVER output cycle.
- OVER:
  - Output over planes.
  - start -> TITLE.
- start and game_over are ignored in FLASH and WIPE.
- tick coinciding with a state transition:
  - The tick is consumed only by the state it arrives in.
  - A new state's counters start from 0 on the following cycle.
- Snapshot is written only on the PLAY->FLASH edge and holds through FLASH and WIPE.
- Counter widths:
  - tick_cnt and tog_cnt are sized by $clog2(param+1).
  - No wrap is permitted: transitions fire before overflow.

Test Plan:
- Reset with reset_n=0 mid-WIPE, title_red=16'hFFFF in all rows -> outputs 0 and mode=0 immediately. One cycle after reset_n rises, RedPixels=all 16'hFFFF.
- TITLE, start pulse -> mode=1 next cycle, play_en=1. Drive play_grn[3]=16'h00F0 -> GrnPixels[3]=16'h00F0 one cycle later. A game_over pulse 1 cycle before start has no effect.
- BLINK_TICKS=2, FLASH_TOGGLES=4, game_over with play_red[0]=16'h8001:
  - play_en=0 next cycle.
  - Outputs alternate snapshot/zero every 2 ticks.
  - Play inputs changing during FLASH do not affect the output.
  - mode=3 on the cycle after the 8th tick.
- WIPE with over_red rows=16'hAAAA, snapshot rows=16'h5555 -> after k ticks rows 0..k-1 read 16'hAAAA and the rest 16'h5555. After 16 ticks mode=4 and all rows read 16'hAAAA.
- OVER, start -> mode=0, title planes shown next cycle. Then start -> PLAY with play_en=1.
- PLAY, start and game_over in the same cycle -> mode=2, snapshot captured. tick held 0 for 100 cycles -> state, phase and output unchanged.
